alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor of the 4-bit registered ALU wrapper. It takes WIDTH-bit operands and a 4-bit opcode over a valid/ready input channel and returns a registered result with C/Z/N/V flags over a valid/ready output channel. Single-cycle ops are fully pipelined at one result per clock. MUL is a multi-cycle shift-add sequencer. The stored carry feeds chained ADC/SBC for multi-word arithmetic.

## Interface
- WIDTH, 8, operand/result width; legal values ≥2, power of two.
- SHW (localparam), clog2(WIDTH), shift-amount width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block accepts; transfer when in_valid && in_ready.
- a, b  in  WIDTH  operands.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 LSL, 7 LSR, 8 ASR, 9 ROL, 10 ROR, 11 ADC, 12 SBC, 13 MUL, 14–15 reserved.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result; transfer when out_valid && out_ready.
- result  out  WIDTH  registered result.
- carry, zero, negative, overflow  out  1 each  registered flags.

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE: `in_ready = !out_valid || out_ready`.
  - Accepting a non-MUL op loads the output register next edge.
  - Accepting MUL latches a, b; clears a 2·WIDTH accumulator; counter ← WIDTH; goes to MUL.
- MUL: one shift-add step per edge. After WIDTH steps go to DONE. `in_ready = 0`.
- DONE: loads the output register when `!out_valid || out_ready`, then goes to IDLE. `in_ready = 0`.
- Arithmetic:
  - ADD = a+b.
  - SUB = a+~b+1.
  - ADC = a+b+carry.
  - SBC = a+~b+carry.
  - In all four, `carry` = carry-out at bit WIDTH. For SUB/SBC, carry=1 means no borrow.
- ADC/SBC use the `carry` output value at the accept edge. That value is the flag of the last result loaded.
- `overflow`: signed overflow for ADD/SUB/ADC/SBC; 0 for all other ops.
- Shifts: amount = b[SHW-1:0].
  - LSL/LSR/ASR: carry = last bit shifted out, 0 when amount=0.
  - ROL/ROR: carry = 0.
- Logic ops (AND/OR/XOR/NOT): carry = 0.
- MUL: result = low WIDTH bits of the unsigned product; carry = 1 iff the high WIDTH bits are non-zero.
- Reserved ops: result 0, carry 0, overflow 0.
- Every load: zero = (result==0), negative = result[WIDTH-1].
- Output register and flags hold while `out_valid && !out_ready`. Nothing changes except on a load.
- Every load sets out_valid.
- An output transfer with no simultaneous load clears out_valid.
- Simultaneous output transfer and new load: new data replaces old, out_valid stays 1.

## Timing
- Reset (async assert, sync-release safe):
  - result=0, carry=0, zero=0, negative=0, overflow=0, out_valid=0.
  - FSM=IDLE, counter=0.
  - in_ready=1 once out of reset.
- Non-MUL latency: accept at edge k → out_valid and data visible after edge k+1.
- Throughput is 1/clk with out_ready held high.
- MUL latency: accept at edge k → steps at edges k+1..k+WIDTH → load at edge k+WIDTH+1 if the output is free; DONE waits otherwise.
- MUL blocks new accepts until the DONE→IDLE edge.
- No combinational path from in_valid to out_valid.
- in_ready depends combinationally on out_ready and the FSM state only.
- rst_n asserted mid-MUL: abort immediately, discard the partial product, return to IDLE. No result is emitted.
- in_valid is ignored while in_ready=0. The source must hold a, b and op stable until the transfer.

## Test plan
- Reset, WIDTH=8:
  - Stimulus: hold reset, then release with in_valid=0.
  - Check: all outputs 0 and out_valid=0 during reset; in_ready=1 after release.
- ADD/SUB flags, back-to-back with out_ready=1:
  - ADD 0xF0,0x20 → result 0x10, C1, V0, N0.
  - ADD 0x7F,0x01 → 0x80, C0, V1, N1.
  - SUB 0x50,0x70 → 0xE0, C0, N1, V0.
  - SUB 0x33,0x33 → 0x00, C1, Z1.
  - Each result appears one cycle after its accept.
- Chained 16-bit add:
  - ADD 0xFF,0x01 → 0x00, C1.
  - Then ADC 0x12,0x34 → 0x47, C0.
- Shifts:
  - LSL 0x81 by 1 → 0x02, C1.
  - ASR 0x80 by 3 → 0xF0, C0.
  - ROR 0x01 by 1 → 0x80, C0.
  - LSR 0x0F by 0 → 0x0F, C0.
- MUL:
  - MUL 0x12,0x34 → result 0xA8, C1, out_valid 9 cycles after accept; in_ready low throughout.
  - MUL 0x0F,0x0F → 0xE1, C0.
  - Repeat with out_ready=0 for 5 cycles at completion: DONE holds, data is emitted intact, no accept occurs.
- Backpressure and reset:
  - Stream 4 ADDs with out_ready toggling: every result is delivered exactly once, in order, with none lost or duplicated.
  - Assert rst_n low at MUL step 4: outputs go to 0, and the next accepted ADD completes normally.

Source files
------------

// File: rtl/alu_pipe.sv
// WIDTH-bit ALU with valid/ready input and output channels, registered result
// and C/Z/N/V flags, chained carry for ADC/SBC and a shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);
  // Valid/ready: a transfer happens on a rising edge where valid && ready; a
  // source holds its payload stable until then, and no valid depends on ready.
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_ADC = 4'd11;
  localparam logic [3:0] OP_SBC = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   result_q;
  logic               carry_q, zero_q, neg_q, ovf_q, out_valid_q;

  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   addend;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic               add_v;
  logic [WIDTH:0]     lsl_w, lsr_w, asr_w;
  logic [2*WIDTH-1:0] rol_w, ror_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  logic               load_en;
  logic [WIDTH-1:0]   load_res;
  logic               load_c, load_v;

  // The extra bit on each shift vector catches the last bit shifted out.
  always_comb begin
    sh      = b[SHW-1:0];
    addend  = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    cin     = (op == OP_SUB) ? 1'b1 :
              ((op == OP_ADC || op == OP_SBC) ? carry_q : 1'b0);
    sum     = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
    add_v   = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    lsl_w   = {1'b0, a} << sh;
    lsr_w   = {a, 1'b0} >> sh;
    asr_w   = $unsigned($signed({a, 1'b0}) >>> sh);
    rol_w   = {a, a} << sh;
    ror_w   = {a, a} >> sh;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_v;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_LSL: begin
        alu_res = lsl_w[WIDTH-1:0];
        alu_c   = lsl_w[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_w[WIDTH:1];
        alu_c   = lsr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[WIDTH:1];
        alu_c   = asr_w[0];
      end
      OP_ROL: alu_res = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR: alu_res = ror_w[WIDTH-1:0];
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    in_ready = 1'b0;
    load_en  = 1'b0;
    load_res = alu_res;
    load_c   = alu_c;
    load_v   = alu_v;
    case (state_q)
      S_IDLE: begin
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready) begin
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_FULL;
            state_d  = S_MUL;
          end else begin
            load_en = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q || out_ready) begin
          load_en  = 1'b1;
          load_res = acc_q[WIDTH-1:0];
          load_c   = |acc_q[2*WIDTH-1:WIDTH];
          load_v   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // A load always wins over a simultaneous output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (load_en) begin
        result_q <= load_res;
        carry_q  <= load_c;
        zero_q   <= (load_res == '0);
        neg_q    <= load_res[WIDTH-1];
        ovf_q    <= load_v;
      end
      if (load_en)        out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign negative    = neg_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=8: directed vector table, multi-cycle MUL and
// reset sequences, randomized traffic against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_ADC = 4'd11;
  localparam logic [3:0] OP_SBC = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_RSV = 4'd14;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         carry, zero, negative, overflow;
  logic [1:0]   dbg_state;

  int           n_vec = 0;
  int           n_err = 0;
  logic         model_carry = 1'b0;
  logic [W+3:0] exp_q[$];
  bit           tog_run = 1'b0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [W+3:0] act, input logic [W+3:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got res/CZNV 0x%0h/%b, required 0x%0h/%b at %0t",
               name, act[W+3:4], act[3:0], req[W+3:4], req[3:0], $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic, returns {res, C, Z, N, V}.
  function automatic logic [W+3:0] ref_model(input logic [3:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic ci);
    int ua, ub, sa, sb, sr, r, n, p;
    logic c, v;
    logic [W-1:0] rr;
    ua = int'(x);
    ub = int'(y);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    n  = ub % 8;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    sr = 0;
    case (o)
      OP_ADD: begin r = ua + ub; sr = sa + sb; end
      OP_SUB: begin r = ua + (255 - ub) + 1; sr = sa - sb; end
      OP_ADC: begin r = ua + ub + int'(ci); sr = sa + sb + int'(ci); end
      OP_SBC: begin r = ua + (255 - ub) + int'(ci); sr = sa - sb - 1 + int'(ci); end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_NOT: r = 255 - ua;
      OP_LSL: begin r = (ua << n) & 255; c = (n == 0) ? 1'b0 : 1'(ua >> (8 - n)); end
      OP_LSR: begin r = ua >> n; c = (n == 0) ? 1'b0 : 1'(ua >> (n - 1)); end
      OP_ASR: begin r = (sa >>> n) & 255; c = (n == 0) ? 1'b0 : 1'(ua >> (n - 1)); end
      OP_ROL: r = ((ua << n) | (ua >> (8 - n))) & 255;
      OP_ROR: r = ((ua >> n) | (ua << (8 - n))) & 255;
      OP_MUL: begin p = ua * ub; r = p & 255; c = (p > 255); end
      default: r = 0;
    endcase
    if (o == OP_ADD || o == OP_SUB || o == OP_ADC || o == OP_SBC) begin
      c = (r > 255);
      v = (sr > 127) || (sr < -128);
      r = r & 255;
    end
    rr = r[W-1:0];
    return {rr, c, (rr == 0), rr[W-1], v};
  endfunction

  // driver: present one operation and hold it until the transfer edge
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int guard;
    logic [W+3:0] e;
    guard = 0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 200) begin
      step();
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required accept", guard);
      in_valid = 1'b0;
    end else begin
      e = ref_model(o, x, y, model_carry);
      model_carry = e[3];
      exp_q.push_back(e);
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    chk_int(name, exp_q.size(), 0);
  endtask

  // scoreboard: every output transfer is matched against the expected queue
  initial begin
    forever begin
      @(negedge clk);
      #5;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got result 0x%0h, required no output at %0t", result, $time);
        end else begin
          chk_word("scoreboard", {result, carry, zero, negative, overflow}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    while (1) begin
      @(negedge clk);
      #1;
      if (tog_run) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic mul_wait(input string name);
    in_valid = 1'b1;
    op = OP_ADD;
    a = 8'h01;
    b = 8'h01;
    for (int i = 0; i <= 8; i++) begin
      chk_bit({name, "_busy_ready"}, in_ready, 1'b0);
      chk_bit({name, "_busy_valid"}, out_valid, 1'b0);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{OP_SUB, 8'h50, 8'h70, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{OP_SUB, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{OP_ADC, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{OP_LSL, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{OP_ASR, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{OP_ROR, 8'h01, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{OP_LSR, 8'h0F, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[12] = '{OP_XOR, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{OP_NOT, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[14] = '{OP_ROL, 8'h81, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{OP_RSV, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[16] = '{OP_SBC, 8'h10, 8'h01, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0};

    // reset
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    op = '0;
    step();
    step();
    chk_word("reset_outputs", {result, carry, zero, negative, overflow}, '0);
    chk_bit("reset_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    step();
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_bit("reset_idle_valid", out_valid, 1'b0);

    // directed table, back-to-back with out_ready high
    for (int i = 0; i < NV; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b);
      chk_bit($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk_word($sformatf("vec%0d_data", i), {result, carry, zero, negative, overflow},
               {vt[i].res, vt[i].c, vt[i].z, vt[i].n, vt[i].v});
    end

    // MUL latency and blocking
    send(OP_MUL, 8'h12, 8'h34);
    mul_wait("mul1");
    chk_bit("mul1_valid", out_valid, 1'b1);
    chk_word("mul1_data", {result, carry, zero, negative, overflow}, {8'hA8, 4'b1010});
    send(OP_MUL, 8'h0F, 8'h0F);
    mul_wait("mul2");
    chk_bit("mul2_valid", out_valid, 1'b1);
    chk_word("mul2_data", {result, carry, zero, negative, overflow}, {8'hE1, 4'b0010});

    // MUL completing into a stalled consumer
    send(OP_MUL, 8'hFF, 8'hFF);
    out_ready = 1'b0;
    mul_wait("mul3");
    chk_word("mul3_data", {result, carry, zero, negative, overflow}, {8'h01, 4'b1000});
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_bit("mul3_hold_valid", out_valid, 1'b1);
      chk_bit("mul3_hold_ready", in_ready, 1'b0);
      chk_word("mul3_hold_data", {result, carry, zero, negative, overflow}, {8'h01, 4'b1000});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk_bit("mul3_once", out_valid, 1'b0);
    drain("mul3_drain");

    // four ADDs under toggling backpressure
    tog_run = 1'b1;
    for (int i = 0; i < 4; i++) send(OP_ADD, W'($urandom()), W'($urandom()));
    tog_run = 1'b0;
    step();
    out_ready = 1'b1;
    drain("bp_drain");

    // randomized traffic against the reference model
    tog_run = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(4'($urandom_range(0, 15)), W'($urandom()), W'($urandom()));
    end
    tog_run = 1'b0;
    step();
    out_ready = 1'b1;
    drain("rand_drain");

    // reset during MUL step 4
    send(OP_MUL, 8'hA5, 8'h3C);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_carry = 1'b0;
    chk_word("midmul_reset_outputs", {result, carry, zero, negative, overflow}, '0);
    chk_bit("midmul_reset_valid", out_valid, 1'b0);
    step();
    chk_int("midmul_reset_state", int'(dbg_state), 0);
    rst_n = 1'b1;
    step();
    chk_bit("midmul_in_ready", in_ready, 1'b1);
    send(OP_ADD, 8'h05, 8'h03);
    chk_bit("post_reset_valid", out_valid, 1'b1);
    chk_word("post_reset_data", {result, carry, zero, negative, overflow}, {8'h08, 4'b0000});
    drain("post_reset_drain");
    for (int i = 0; i < 12; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
